instr_mem_ctrl: RTL

Instruction-side memory controller directly downstream of the instruction memory decoder. It accepts the decoder's OBI-style instruction request channel (req/gnt/rvalid/addr/rdata/err) for every fetch outside the recovery ROM window. It performs range and alignment checks and drives a single-port synchronous instruction SRAM with a programmable number of wait states. Each accepted fetch returns exactly one response, in order, with one fetch outstanding at a time.

---
 rtl/instr_mem_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/instr_mem_ctrl.sv
// Instruction-side SRAM controller: range/alignment check, programmable wait
// states before a single-cycle SRAM read, one fetch outstanding at a time.
`timescale 1ns/1ps
module instr_mem_ctrl #(
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE    = 32'h0004_0000,
    parameter int          WAIT_CYCLES = 0,
    localparam int         ADDR_W      = $clog2(MEM_SIZE / 4)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MEM, S_RESP, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [32:0]       mem_end;
    logic              addr_err;
    logic [ADDR_W-1:0] word_addr;

    // 33-bit compare so a window ending at 2^32 does not wrap to zero
    assign mem_end   = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    assign addr_err  = ({1'b0, instr_addr_i} < {1'b0, MEM_BASE}) ||
                       ({1'b0, instr_addr_i} >= mem_end) ||
                       (instr_addr_i[1:0] != 2'b00);
    assign word_addr = ADDR_W'((instr_addr_i - MEM_BASE) >> 2);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        instr_gnt_o    = 1'b0;
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = 32'h0;
        instr_err_o    = 1'b0;

        case (state_q)
            S_IDLE, S_RESP, S_ERR: instr_gnt_o = instr_req_i && !rst_i;
            default: ;
        endcase

        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_MEM;
            end
            S_MEM:  state_d = S_RESP;
            S_RESP: begin
                instr_rvalid_o = 1'b1;
                instr_rdata_o  = mem_rdata_i;
                state_d        = S_IDLE;
            end
            S_ERR: begin
                instr_rvalid_o = 1'b1;
                instr_err_o    = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // a grant in IDLE/RESP/ERR overrides the fall-back to IDLE
        if (instr_gnt_o) begin
            if (addr_err) begin
                state_d = S_ERR;
            end else if (WAIT_CYCLES == 0) begin
                state_d = S_MEM;
            end else begin
                state_d = S_WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_req_o <= (state_d == S_MEM);
            if (instr_gnt_o && !addr_err) mem_addr_o <= word_addr;
        end
    end

endmodule
